// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage of the 9-bit processor.
// Owns the PC, drives the synchronous instruction ROM (read data arrives one
// cycle after the address), holds the 16-entry jump-target LUT, and sequences
// start/halt of a program run.
// Optional build macro: FETCH_PERF_EN adds saturating instr/stall counters.
module fetch_unit #(
    parameter int         PC_W    = 10,
    parameter logic [8:0] HALT_OP = 9'h1FF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [3:0]      branch_idx,
    input  logic            lut_we,
    input  logic [3:0]      lut_addr,
    input  logic [PC_W-1:0] lut_data,
    output logic [PC_W-1:0] imem_addr,
    input  logic [8:0]      imem_data,
    output logic [8:0]      instr,
    output logic            instr_valid,
    output logic [PC_W-1:0] pc,
    output logic            done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     instr_count,
    output logic [15:0]     stall_count
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] lut_q [16];
    logic [PC_W-1:0] lut_d [16];
    logic            start_ok;

    // A start pulse only matters outside RUN; it also clears the perf counters
    assign start_ok = start && (state_q != RUN);

    // ROM data always corresponds to pc_q while running, so it is the instruction
    assign instr       = imem_data;
    assign instr_valid = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign pc          = pc_q;

    // Next-state / next-PC; imem_addr follows pc_d so the ROM keeps pace with zero bubbles
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imem_addr = pc_q;
        case (state_q)
            RUN: begin
                // stall > halt > branch > sequential
                if (!stall) begin
                    if (imem_data == HALT_OP)
                        state_d = DONE;
                    else if (branch_taken)
                        pc_d = lut_q[branch_idx];
                    else
                        pc_d = pc_q + 1'b1;
                end
                imem_addr = pc_d;
            end
            default: begin
                if (start) begin
                    state_d   = RUN;
                    pc_d      = '0;
                    imem_addr = '0;
                end
            end
        endcase
    end

    // LUT writes are only accepted while no program is running
    always_comb begin
        lut_d = lut_q;
        if (lut_we && state_q != RUN)
            lut_d[lut_addr] = lut_data;
    end

    // State, PC and jump LUT registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            for (int i = 0; i < 16; i++)
                lut_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lut_q   <= lut_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [15:0] icnt_q, icnt_d, scnt_q, scnt_d;

    assign instr_count = icnt_q;
    assign stall_count = scnt_q;

    // Saturating counters of issued instructions and stalled RUN cycles
    always_comb begin
        icnt_d = icnt_q;
        scnt_d = scnt_q;
        if (start_ok) begin
            icnt_d = '0;
            scnt_d = '0;
        end else if (state_q == RUN) begin
            if (!stall && icnt_q != 16'hFFFF)
                icnt_d = icnt_q + 16'd1;
            if (stall && scnt_q != 16'hFFFF)
                scnt_d = scnt_q + 16'd1;
        end
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icnt_q <= '0;
            scnt_q <= '0;
        end else begin
            icnt_q <= icnt_d;
            scnt_q <= scnt_d;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 9-bit processor. Holds the program counter, drives the synchronous instruction memory, and presents one instruction per cycle to the decoder together with a valid flag. It also owns the 16-entry jump-target lookup table indexed by the 4-bit jump immediate, and the start/halt sequencing of a program run.

## Interface
- PC_W, 10, program counter / instruction memory address width
- HALT_OP, 9'h1FF, instruction encoding that ends a run
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run at PC 0
- stall  in  1  hold PC and current instruction
- branch_taken  in  1  current instruction's jump resolves taken
- branch_idx  in  4  jump immediate (decoder imm[3:0]); selects LUT entry
- lut_we  in  1  jump LUT write enable
- lut_addr  in  4  jump LUT write index
- lut_data  in  PC_W  jump LUT write data (absolute target)
- imem_addr  out  PC_W  address to synchronous ROM (data returned next cycle)
- imem_data  in  9  ROM read data
- instr  out  9  instruction to decoder (= imem_data)
- instr_valid  out  1  instr is a live instruction
- pc  out  PC_W  address of instr
- done  out  1  run finished (halt fetched)

## Operation
- States: IDLE (reset), RUN, DONE.
- IDLE/DONE: instr_valid=0; imem_addr = start ? 0 : pc. start -> RUN, pc<=0. DONE keeps pc at the halt address and done=1 until start.
- RUN: instr_valid=1; imem_addr = pc_next, so imem_data always equals mem[pc].
- pc_next priority (RUN): stall -> pc; instr==HALT_OP -> pc (state -> DONE); branch_taken -> lut[branch_idx]; else pc+1 modulo 2^PC_W (wraps to 0).
- Halt beats branch_taken in the same cycle. Stall beats halt: under stall, halt is not acted on until the cycle stall drops.
- start in RUN ignored. lut_we honoured only in IDLE/DONE; ignored in RUN.
- LUT: 16 x PC_W registers, written on clk edge when lut_we in a legal state.

## Timing
- Reset (async, immediate): state=IDLE, pc=0, done=0, instr_valid=0, all LUT entries 0, imem_addr=0.
- Start latency: start at edge N -> instr_valid=1, pc=0, instr=mem[0] in cycle N+1.
- Throughput: one instruction per cycle; taken branch has zero bubbles (target instruction valid next cycle).
- branch_taken/branch_idx/stall sampled combinationally in the cycle the instruction is presented; path into imem_addr is combinational.
- Halt: HALT_OP presented in cycle K with instr_valid=1; cycle K+1 state=DONE, done=1, instr_valid=0.
- rst_n asserted mid-run: everything returns to reset values asynchronously; LUT contents lost.

## Configuration
- FETCH_PERF_EN defined: adds outputs instr_count[15:0] (increments each cycle instr_valid & ~stall) and stall_count[15:0] (increments each RUN cycle with stall); both saturate at 16'hFFFF, clear to 0 on reset and on start.
- Undefined: ports and counters absent; all other behaviour identical.

## Test plan
- Reset then start with ROM {0:0x001,1:0x002,2:0x1FF} -> pc 0,1,2 on consecutive cycles, instr_valid high 3 cycles, done=1 next cycle, pc stays 2.
- Write lut[5]=0x040 in IDLE, start, branch_taken with branch_idx=5 at pc=3 -> next cycle pc=0x040, instr=mem[0x040], no invalid cycle.
- stall held 3 cycles at pc=7 -> pc and instr unchanged 3 cycles, pc=8 the cycle after stall drops; with FETCH_PERF_EN stall_count=3.
- HALT_OP at pc=9 with branch_taken=1 -> DONE, pc=9, branch ignored; lut_we during RUN leaves LUT unchanged.
- PC_W=4, straight-line ROM -> pc 15 followed by 0; rst_n low mid-run -> pc=0, done=0, instr_valid=0 immediately, LUT reads 0.
